// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
// 640x480@60 scan generator and pixel sink. It derives a pixel clock-enable
// from the system clock and presents scan coordinates to the renderers. One
// pixel period later it drives the returned colour and the sync pulses to the
// connector.
//
// Ports
//   clk          system clock (100 MHz)
//   rstn         asynchronous active-low reset
//   icolor[11:0] {R,G,B} from the renderer mux, valid one clk after cx/cy
//   cx[9:0]      visible column (0 outside the visible area)
//   cy[8:0]      visible row    (0 outside the visible area)
//   active       cx/cy address a visible pixel
//   pix_ce       one-clk pulse per pixel period
//   frame_start  one-clk pulse when pixel (0,0) is first presented
//   hs, vs       active-low syncs, aligned with r/g/b
//   r, g, b      4-bit colour channels, forced to 0 during blanking
module vga_scan_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4     // must be >= 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [11:0] icolor,
   output logic [9:0]  cx,
   output logic [8:0]  cy,
   output logic        active,
   output logic        pix_ce,
   output logic        frame_start,
   output logic        hs,
   output logic        vs,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       hcnt;
   logic [9:0]       vcnt;
   logic             vis_now;
   logic             hsync_now;
   logic             vsync_now;
   logic             hsync_q;
   logic             vsync_q;

   // Pixel divider runs as a down-counter; terminal count zero is the
   // last system clock of the pixel period.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_cnt <= DIV_LOAD;
      end else if (div_cnt == '0) begin
         div_cnt <= DIV_LOAD;
      end else begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   assign pix_ce = (div_cnt == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_ce) begin
         if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
         end else begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end

   assign vis_now   = (hcnt < H_VIS) && (vcnt < V_VIS);
   assign hsync_now = (hcnt >= HS_BEG) && (hcnt < HS_END);
   assign vsync_now = (vcnt >= VS_BEG) && (vcnt < VS_END);

   // Coordinates take the counter value that is about to be left behind.
   // They therefore change on the same edge the counters advance, which
   // gives the renderer the full period minus one clock.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         active  <= 1'b0;
         cx      <= '0;
         cy      <= '0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else if (pix_ce) begin
         active  <= vis_now;
         cx      <= vis_now ? hcnt : '0;
         cy      <= vis_now ? vcnt[8:0] : '0;
         hsync_q <= hsync_now;
         vsync_q <= vsync_now;
      end
   end

   // Output stage closes the pixel that was on cx/cy during the ending
   // period, so the syncs stay aligned with the colour they accompany.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r  <= '0;
         g  <= '0;
         b  <= '0;
         hs <= 1'b1;
         vs <= 1'b1;
      end else if (pix_ce) begin
         {r, g, b} <= active ? icolor : 12'h000;
         hs        <= ~hsync_q;
         vs        <= ~vsync_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_ce && (hcnt == '0) && (vcnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

   localparam int DIV = 4;
   localparam logic [35:0] RST_OBS = {5'b00011, 31'd0};

   typedef struct {
      int ha, hf, hsy, hb, va, vf, vsy, vb;
      bit flat;
   } geom_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [11:0] icolor_a = 12'h000;
   logic [11:0] icolor_b = 12'h000;

   logic [9:0]  cx_a, cx_b;
   logic [8:0]  cy_a, cy_b;
   logic        active_a, active_b, pce_a, pce_b, fs_a, fs_b;
   logic        hs_a, hs_b, vs_a, vs_b;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic [35:0] obs_a, obs_b;

   geom_t ga, gb;
   int    n = 0;
   int    total = 0;
   int    bad = 0;
   int    shown = 0;
   int    phase = 0;

   int first_pce = -1, first_fs_a = -1, first_hs_low = -1;
   int hs_low_cnt = 0, inact_cnt = 0;
   int vs_low_b = 0, lit_b = 0, dark_b = 0;
   int fs_b_prev = -1, fs_b_gap = -1, p2_fs_a = -1;
   logic [9:0]  cap_cx = '1;
   logic [8:0]  cap_cy = '1;
   logic [11:0] cap_rgb = '1;
   logic [19:0] p2_xy = '1;

   always #5 clk = ~clk;

   vga_scan_ctrl dut_a (
      .clk(clk), .rstn(rstn), .icolor(icolor_a),
      .cx(cx_a), .cy(cy_a), .active(active_a), .pix_ce(pce_a),
      .frame_start(fs_a), .hs(hs_a), .vs(vs_a),
      .r(r_a), .g(g_a), .b(b_a)
   );

   vga_scan_ctrl #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(DIV)
   ) dut_b (
      .clk(clk), .rstn(rstn), .icolor(icolor_b),
      .cx(cx_b), .cy(cy_b), .active(active_b), .pix_ce(pce_b),
      .frame_start(fs_b), .hs(hs_b), .vs(vs_b),
      .r(r_b), .g(g_b), .b(b_b)
   );

   assign obs_a = {pce_a, fs_a, active_a, hs_a, vs_a, cx_a, cy_a, r_a, g_a, b_a};
   assign obs_b = {pce_b, fs_b, active_b, hs_b, vs_b, cx_b, cy_b, r_b, g_b, b_b};

   // Renderer stand-in: one registered stage returning {cx[3:0], cy[3:0], A}.
   always @(posedge clk) icolor_a <= {cx_a[3:0], cy_a[3:0], 4'hA};

   // Clocks elapsed since reset release.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) n <= 0;
      else       n <= n + 1;
   end

   // Expected outputs after t clocks since release. Pixel p is presented
   // from clock DIV*(p+1) on; its colour and syncs appear one period later.
   function automatic logic [35:0] model(input geom_t gm, input int t);
      int ht, vt, k, p, h, v;
      logic pce, fs, act, hsn, vsn;
      logic [9:0]  x;
      logic [8:0]  y;
      logic [11:0] rgb;
      ht  = gm.ha + gm.hf + gm.hsy + gm.hb;
      vt  = gm.va + gm.vf + gm.vsy + gm.vb;
      pce = (t % DIV) == (DIV - 1);
      fs = 1'b0; act = 1'b0; hsn = 1'b1; vsn = 1'b1;
      x = '0; y = '0; rgb = '0;
      k = t / DIV;
      if (k >= 1) begin
         p   = k - 1;
         h   = p % ht;
         v   = (p / ht) % vt;
         act = (h < gm.ha) && (v < gm.va);
         if (act) begin
            x = 10'(h);
            y = 9'(v);
         end
         fs = ((t % DIV) == 0) && ((p % (ht * vt)) == 0);
      end
      if (k >= 2) begin
         p   = k - 2;
         h   = p % ht;
         v   = (p / ht) % vt;
         hsn = !((h >= gm.ha + gm.hf) && (h < gm.ha + gm.hf + gm.hsy));
         vsn = !((v >= gm.va + gm.vf) && (v < gm.va + gm.vf + gm.vsy));
         if ((h < gm.ha) && (v < gm.va))
            rgb = gm.flat ? 12'hFFF : {h[3:0], v[3:0], 4'hA};
      end
      return {pce, fs, act, hsn, vsn, x, y, rgb};
   endfunction

   task automatic check(input string name, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Per-cycle compare against the model, plus statistics for the literal checks.
   always @(negedge clk) begin
      logic [35:0] ea, eb;
      if (phase > 0) begin
         ea = model(ga, n);
         eb = model(gb, n);
         total += 2;
         if (obs_a !== ea) begin
            bad++;
            if (shown < 20) $display("FAIL scan_a n=%0d got=%h want=%h", n, obs_a, ea);
            shown++;
         end
         if (obs_b !== eb) begin
            bad++;
            if (shown < 20) $display("FAIL scan_b n=%0d got=%h want=%h", n, obs_b, eb);
            shown++;
         end
      end
      if (phase == 1) begin
         if (first_pce < 0 && pce_a) first_pce = n;
         if (first_fs_a < 0 && fs_a) first_fs_a = n;
         if (n < 3200 && !hs_a) begin
            hs_low_cnt++;
            if (first_hs_low < 0) first_hs_low = n;
         end
         if (n >= 4 && n < 3204 && !active_a) inact_cnt++;
         if (n == 9624) begin
            cap_cx = cx_a;
            cap_cy = cy_a;
         end
         if (n == 9628) cap_rgb = {r_a, g_a, b_a};
         if (fs_b) begin
            if (fs_b_prev >= 0 && fs_b_gap < 0) fs_b_gap = n - fs_b_prev;
            fs_b_prev = n;
         end
         if (n >= 924 && n < 1844) begin
            if (!vs_b) vs_low_b++;
            if ({r_b, g_b, b_b} == 12'hFFF) lit_b++;
            if ({r_b, g_b, b_b} == 12'h000) dark_b++;
         end
      end
      if (phase == 2 && p2_fs_a < 0 && fs_a) begin
         p2_fs_a = n;
         p2_xy   = {active_a, cx_a, cy_a};
      end
   end

   initial begin
      bit found;
      ga = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      gb = '{16, 2, 3, 2, 6, 1, 2, 1, 1'b1};
      icolor_b = 12'hFFF;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_a", obs_a, RST_OBS);
      check("reset_b", obs_b, RST_OBS);

      rstn  = 1'b1;
      phase = 1;
      repeat (9700) @(negedge clk);

      check("first_pix_ce_clk", first_pce, 3);
      check("first_frame_start_clk", first_fs_a, 4);
      check("hs_low_clks_line0", hs_low_cnt, 384);
      check("hs_low_after_cx0", first_hs_low - first_fs_a, 2628);
      check("hblank_clks_line0", inact_cnt, 640);
      check("cx_at_5_3", cap_cx, 5);
      check("cy_at_5_3", cap_cy, 3);
      check("rgb_at_5_3", cap_rgb, 12'h53A);
      check("small_frame_period", fs_b_gap, 920);
      check("small_vs_low_clks", vs_low_b, 184);
      check("small_lit_clks", lit_b, 384);
      check("small_dark_clks", dark_b, 536);

      found = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (cx_a == 10'd300 && cy_a == 9'd3 && active_a) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_300_3", found, 1);

      #2 rstn = 1'b0;
      #1;
      check("async_reset_a", obs_a, RST_OBS);
      check("async_reset_b", obs_b, RST_OBS);
      repeat (3) @(negedge clk);
      rstn  = 1'b1;
      phase = 2;
      repeat (1200) @(negedge clk);

      check("restart_frame_start_clk", p2_fs_a, 4);
      check("restart_xy", p2_xy, {1'b1, 10'd0, 9'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
